// File: rtl/id_scoreboard_if.sv
// Decode/writeback/flush bundle for the register scoreboard.
// The master side drives the decoded fields and the writeback events.
// The slave side (the scoreboard) returns the hazard decision and its state.
interface id_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rs_use;
  logic             id_rt_use;
  logic             id_src_fp;
  logic [4:0]       id_dst;
  logic             id_dst_wr;
  logic             id_dst_fp;
  logic             id_is_mul;
  logic             wb_valid;
  logic [4:0]       wb_dst;
  logic             wb_fp;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [31:0]      gpr_busy;
  logic [31:0]      fpr_busy;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_src_fp,
           id_dst, id_dst_wr, id_dst_fp, id_is_mul,
           wb_valid, wb_dst, wb_fp, flush,
    input  stall, issue, gpr_busy, fpr_busy, mul_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_src_fp,
           id_dst, id_dst_wr, id_dst_fp, id_is_mul,
           wb_valid, wb_dst, wb_fp, flush,
    output stall, issue, gpr_busy, fpr_busy, mul_busy, stall_cycles
  );
endinterface

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard: pending-write bits for GPR/FPR plus an
// occupancy counter for the multi-cycle FPU multiplier. Holds decode on
// RAW, WAW and multiplier structural hazards. There is no writeback bypass.
module id_scoreboard #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          reset,
  id_scoreboard_if.slave sb
);
  logic [31:0]      gpr_q, gpr_d;
  logic [31:0]      fpr_q, fpr_d;
  logic [3:0]       mul_cnt, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt;
  logic             raw, waw, strct, stall, issue;

  // Bit 0 of gpr_q is never set, so r0 can never raise a hazard.
  function automatic logic busy_bit(input logic [31:0] g, input logic [31:0] f,
                                    input logic fp, input logic [4:0] idx);
    return fp ? f[idx] : g[idx];
  endfunction

  // Hazard detection from registered state only.
  always_comb begin
    raw   = (sb.id_rs_use & busy_bit(gpr_q, fpr_q, sb.id_src_fp, sb.id_rs)) |
            (sb.id_rt_use & busy_bit(gpr_q, fpr_q, sb.id_src_fp, sb.id_rt));
    waw   = sb.id_dst_wr & busy_bit(gpr_q, fpr_q, sb.id_dst_fp, sb.id_dst);
    strct = sb.id_is_mul & (mul_cnt != 4'd0);
    stall = sb.id_valid & (raw | waw | strct);
    issue = sb.id_valid & ~stall;
  end

  // Next busy bits: writeback clears first so a same-register issue set wins;
  // flush overrides everything.
  always_comb begin
    gpr_d = gpr_q;
    fpr_d = fpr_q;
    if (sb.wb_valid) begin
      if (sb.wb_fp) fpr_d[sb.wb_dst] = 1'b0;
      else          gpr_d[sb.wb_dst] = 1'b0;
    end
    if (issue && sb.id_dst_wr) begin
      if (sb.id_dst_fp) fpr_d[sb.id_dst] = 1'b1;
      else              gpr_d[sb.id_dst] = 1'b1;
    end
    gpr_d[0] = 1'b0;
    if (sb.flush) begin
      gpr_d = '0;
      fpr_d = '0;
    end
  end

  // Multiplier occupancy: reload on a multiply issue, else count down to 0.
  always_comb begin
    mul_cnt_d = mul_cnt;
    if (sb.flush)                  mul_cnt_d = 4'd0;
    else if (issue && sb.id_is_mul) mul_cnt_d = 4'(MUL_LATENCY - 1);
    else if (mul_cnt != 4'd0)      mul_cnt_d = mul_cnt - 4'd1;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr_q   <= '0;
      fpr_q   <= '0;
      mul_cnt <= '0;
    end else begin
      gpr_q   <= gpr_d;
      fpr_q   <= fpr_d;
      mul_cnt <= mul_cnt_d;
    end
  end

  // Saturating stall-cycle counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign sb.stall        = stall;
  assign sb.issue        = issue;
  assign sb.gpr_busy     = gpr_q;
  assign sb.fpr_busy     = fpr_q;
  assign sb.mul_busy     = (mul_cnt != 4'd0);
  assign sb.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard (MUL_LATENCY=4, narrow 4-bit stall counter
// so saturation is reachable quickly).
module tb_id_scoreboard;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  id_scoreboard_if #(.CNT_W(CW)) sb ();

  id_scoreboard #(.MUL_LATENCY(4), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb.id_valid = 0; sb.id_rs = 0; sb.id_rt = 0; sb.id_rs_use = 0; sb.id_rt_use = 0;
    sb.id_src_fp = 0; sb.id_dst = 0; sb.id_dst_wr = 0; sb.id_dst_fp = 0; sb.id_is_mul = 0;
    sb.wb_valid = 0; sb.wb_dst = 0; sb.wb_fp = 0; sb.flush = 0;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12 reset = 1'b0;
    #1;
    chk("rst_gpr", sb.gpr_busy, 0);
    chk("rst_fpr", sb.fpr_busy, 0);
    chk("rst_mul", 32'(sb.mul_busy), 0);
    chk("rst_cnt", 32'(sb.stall_cycles), 0);
    chk("rst_stall", 32'(sb.stall), 0);
    chk("rst_issue", 32'(sb.issue), 0);

    // Plain reader, nothing busy.
    sb.id_valid = 1; sb.id_rs = 3; sb.id_rs_use = 1; #1;
    chk("free_stall", 32'(sb.stall), 0);
    chk("free_issue", 32'(sb.issue), 1);
    idle(); step();

    // RAW on r5.
    sb.id_valid = 1; sb.id_dst = 5; sb.id_dst_wr = 1; #1;
    chk("raw_wr_issue", 32'(sb.issue), 1);
    step(); idle();
    sb.id_valid = 1; sb.id_rs = 5; sb.id_rs_use = 1; #1;
    chk("raw_busy", sb.gpr_busy, 32'h0000_0020);
    chk("raw_t1_stall", 32'(sb.stall), 1);
    step();
    chk("raw_t2_stall", 32'(sb.stall), 1);
    step();
    sb.wb_valid = 1; sb.wb_dst = 5; #1;
    chk("raw_wb_stall", 32'(sb.stall), 1);
    step();
    sb.wb_valid = 0; #1;
    chk("raw_t4_issue", 32'(sb.issue), 1);
    chk("raw_cnt", 32'(sb.stall_cycles), 3);
    idle(); step();

    // r0 write is ignored; JAL to r31.
    sb.id_valid = 1; sb.id_dst = 0; sb.id_dst_wr = 1;
    step();
    chk("r0_busy", sb.gpr_busy, 0);
    sb.id_dst = 31;
    step(); idle();
    chk("jal_busy", sb.gpr_busy, 32'h8000_0000);
    sb.id_valid = 1; sb.id_rt = 31; sb.id_rt_use = 1; sb.id_rs = 0; sb.id_rs_use = 1; #1;
    chk("jal_rd_stall", 32'(sb.stall), 1);
    step();
    sb.wb_valid = 1; sb.wb_dst = 31; #1;
    chk("jal_wb_stall", 32'(sb.stall), 1);
    step();
    sb.wb_valid = 0; #1;
    chk("jal_issue", 32'(sb.issue), 1);
    chk("jal_cnt", 32'(sb.stall_cycles), 5);
    chk("jal_clr", sb.gpr_busy, 0);
    idle(); step();

    // WAW on f2 and a same-edge writeback/issue collision.
    sb.id_valid = 1; sb.id_dst = 2; sb.id_dst_fp = 1; sb.id_dst_wr = 1;
    step();
    chk("waw_busy", sb.fpr_busy, 32'h4);
    chk("waw_stall", 32'(sb.stall), 1);
    chk("waw_gpr_clean", sb.gpr_busy, 0);
    sb.wb_valid = 1; sb.wb_fp = 1; sb.wb_dst = 2;
    step();
    chk("waw_cleared_issue", 32'(sb.issue), 1);
    chk("waw_cnt", 32'(sb.stall_cycles), 6);
    step();
    sb.id_valid = 0; sb.id_dst_wr = 0;
    chk("collide_set_wins", sb.fpr_busy, 32'h4);
    step();
    sb.wb_valid = 0;
    chk("f2_retired", sb.fpr_busy, 0);
    idle(); step();

    // Multiplier structural hazard.
    sb.id_valid = 1; sb.id_is_mul = 1; #1;
    chk("mul_t0_issue", 32'(sb.issue), 1);
    step();
    chk("mul_busy_t1", 32'(sb.mul_busy), 1);
    chk("mul_t1_stall", 32'(sb.stall), 1);
    step();
    chk("mul_t2_stall", 32'(sb.stall), 1);
    step();
    chk("mul_t3_stall", 32'(sb.stall), 1);
    step();
    chk("mul_t4_issue", 32'(sb.issue), 1);
    chk("mul_cnt", 32'(sb.stall_cycles), 9);
    step(); idle();
    // Non-mul with no register hazard goes straight through; sets f1.
    sb.id_valid = 1; sb.id_dst = 1; sb.id_dst_fp = 1; sb.id_dst_wr = 1; #1;
    chk("nonmul_busy", 32'(sb.mul_busy), 1);
    chk("nonmul_issue", 32'(sb.issue), 1);
    step();
    sb.id_dst = 7; sb.id_dst_fp = 0;
    step();
    chk("pre_flush_gpr", sb.gpr_busy, 32'h80);
    chk("pre_flush_fpr", sb.fpr_busy, 32'h2);
    chk("pre_flush_mul", 32'(sb.mul_busy), 1);

    // Flush with a simultaneous issue to r9.
    sb.flush = 1; sb.id_dst = 9; #1;
    chk("flush_issue", 32'(sb.issue), 1);
    step(); idle();
    chk("flush_gpr", sb.gpr_busy, 0);
    chk("flush_fpr", sb.fpr_busy, 0);
    chk("flush_mul", 32'(sb.mul_busy), 0);
    chk("flush_cnt_kept", 32'(sb.stall_cycles), 9);

    // Saturation, then asynchronous reset mid-operation.
    sb.id_valid = 1; sb.id_is_mul = 1; sb.id_dst = 4; sb.id_dst_wr = 1;
    step(); idle();
    sb.id_valid = 1; sb.id_rs = 4; sb.id_rs_use = 1;
    for (int i = 0; i < 8; i++) step();
    chk("sat_cnt", 32'(sb.stall_cycles), 15);
    chk("sat_still_busy", sb.gpr_busy, 32'h10);
    #2 reset = 1'b1;
    #1;
    chk("arst_gpr", sb.gpr_busy, 0);
    chk("arst_mul", 32'(sb.mul_busy), 0);
    chk("arst_cnt", 32'(sb.stall_cycles), 0);
    reset = 1'b0;
    idle();
    sb.wb_valid = 1; sb.wb_dst = 4;
    step();
    idle();
    chk("late_wb", sb.gpr_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
